mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sequences the enabled state registers (PC, IR, data and ALU-out registers) and the register file / memory write strobes across instruction phases. It decodes the opcode and funct-independent ALU class, and generates mux selects. It also handles a ready/wait handshake with the shared instruction/data memory, including a bounded timeout.

---
 rtl/mips_multicycle_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with a bounded memory wait handshake.
// Optional bne support is enabled by defining MIPS_CTRL_BNE_EN.
module mips_multicycle_ctrl #(
  parameter int unsigned p_wait_max = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif
  localparam logic [7:0] WAIT_MAX = 8'(p_wait_max);

  state_t     state, next;
  logic [7:0] wait_cnt;
  logic       mem_state, timeout, illegal_d;
  logic       pcwrite, branch, taken;

  assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_MAX);

  always_comb begin
    next      = state;
    illegal_d = 1'b0;
    case (state)
      FETCH:    if (mem_ready) next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECUTE;
          OP_BEQ:       next = BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       next = BRANCH;
`endif
          OP_ADDI:      next = ADDIEXEC;
          OP_J:         next = JUMP;
          default: begin
            next      = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR:   next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    if (mem_ready) next = MEMWB;
      MEMWB:    next = FETCH;
      MEMWR:    if (mem_ready) next = FETCH;
      EXECUTE:  next = ALUWB;
      ALUWB:    next = FETCH;
      BRANCH:   next = FETCH;
      ADDIEXEC: next = ADDIWB;
      ADDIWB:   next = FETCH;
      JUMP:     next = FETCH;
      default:  next = FETCH;
    endcase
    if (timeout) next = FETCH;
  end

`ifdef MIPS_CTRL_BNE_EN
  logic is_bne;
`endif

  // A timeout re-enters FETCH from FETCH, so it must clear the counter explicitly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      mem_err  <= 1'b0;
`ifdef MIPS_CTRL_BNE_EN
      is_bne   <= 1'b0;
`endif
    end else begin
      state   <= next;
      illegal <= illegal_d;
      mem_err <= timeout;
      if ((next != state) || timeout)
        wait_cnt <= '0;
      else if (mem_state && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
`ifdef MIPS_CTRL_BNE_EN
      if (state == DECODE) is_bne <= (op == OP_BNE);
`endif
    end
  end

`ifdef MIPS_CTRL_BNE_EN
  assign taken = is_bne ? ~zero : zero;
`else
  assign taken = zero;
`endif

  logic req_s, irw_s, rw_s, mw_s;

  always_comb begin
    req_s    = 1'b0;
    irw_s    = 1'b0;
    rw_s     = 1'b0;
    mw_s     = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    case (state)
      FETCH: begin
        req_s   = 1'b1;
        alusrcb = 2'b01;
        irw_s   = mem_ready;
        pcwrite = mem_ready;
      end
      DECODE:   alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        req_s = 1'b1;
        iord  = 1'b1;
      end
      MEMWB: begin
        rw_s     = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        req_s = 1'b1;
        iord  = 1'b1;
        mw_s  = mem_ready;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        rw_s   = 1'b1;
        regdst = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:   rw_s = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req  = req_s & ~reset;
  assign irwrite  = irw_s & ~reset;
  assign regwrite = rw_s & ~reset;
  assign memwrite = mw_s & ~reset;
  assign pcen     = (pcwrite | (branch & taken)) & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: per-instruction reference traces versus the control FSM outputs.
module tb_mips_multicycle_ctrl;

  localparam int unsigned P = 3;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = '0;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic mem_req, pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic illegal, mem_err;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.p_wait_max(P)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
    .memwrite(memwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .illegal(illegal), .mem_err(mem_err)
  );

  logic [16:0] obs;
  assign obs = {mem_req, pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
                alusrca, alusrcb, pcsrc, aluop, illegal, mem_err};

  int checks = 0;
  int errors = 0;
  logic [5:0] cur_op = '0;
  logic cur_z = 1'b0;
  logic [1:0] pend = 2'b00;        // {illegal, mem_err} owed to the next FETCH
  logic [1:0] first_flags = 2'b00;

  function automatic logic [16:0] ov(input logic req, pe, irw, rw, mw, io, m2r, rd, asa,
                                     input logic [1:0] asb, pcs, aop);
    return {req, pe, irw, rw, mw, io, m2r, rd, asa, asb, pcs, aop, 2'b00};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic rst, input logic rdy, input logic [16:0] e, input string tag);
    @(negedge clk);
    reset = rst;
    mem_ready = rdy;
    op = cur_op;
    zero = cur_z;
    #1;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s t=%0t: got %b expected %b", tag, $time, obs, e);
    end
  endtask

  task automatic push(input logic rdy, input logic [16:0] e, input string tag);
    step(1'b0, rdy, e | {15'b0, first_flags}, tag);
    first_flags = 2'b00;
  endtask

  // w waits then completion; w beyond the limit means P+1 idle cycles and an abort.
  task automatic mem_phase(input int w, input logic [16:0] busy, input logic [16:0] done,
                           input string tag, output bit ok);
    if (w > int'(P)) begin
      for (int i = 0; i <= int'(P); i++) push(1'b0, busy, tag);
      pend = 2'b01;
      ok = 1'b0;
    end else begin
      for (int i = 0; i < w; i++) push(1'b0, busy, tag);
      push(1'b1, done, tag);
      ok = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic z, input int wf, input int wm,
                           input string tag);
    bit ok;
    cur_op = o;
    cur_z = z;
    first_flags = pend;
    pend = 2'b00;
    mem_phase(wf, ov(1,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00),
                  ov(1,1,1,0,0,0,0,0,0,2'b01,2'b00,2'b00), {tag, ".fetch"}, ok);
    if (!ok) return;
    push(rnd(), ov(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00), {tag, ".decode"});
    case (o)
      LW: begin
        push(rnd(), ov(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), {tag, ".memadr"});
        mem_phase(wm, ov(1,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00),
                      ov(1,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00), {tag, ".memrd"}, ok);
        if (ok) push(rnd(), ov(0,0,0,1,0,0,1,0,0,2'b00,2'b00,2'b00), {tag, ".memwb"});
      end
      SW: begin
        push(rnd(), ov(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), {tag, ".memadr"});
        mem_phase(wm, ov(1,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00),
                      ov(1,0,0,0,1,1,0,0,0,2'b00,2'b00,2'b00), {tag, ".memwr"}, ok);
      end
      RT: begin
        push(rnd(), ov(0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10), {tag, ".exec"});
        push(rnd(), ov(0,0,0,1,0,0,0,1,0,2'b00,2'b00,2'b00), {tag, ".aluwb"});
      end
      BEQ: push(rnd(), ov(0,z,0,0,0,0,0,0,1,2'b00,2'b01,2'b01), {tag, ".branch"});
`ifdef MIPS_CTRL_BNE_EN
      BNE: push(rnd(), ov(0,~z,0,0,0,0,0,0,1,2'b00,2'b01,2'b01), {tag, ".branch"});
`endif
      ADDI: begin
        push(rnd(), ov(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), {tag, ".addiexec"});
        push(rnd(), ov(0,0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00), {tag, ".addiwb"});
      end
      J: push(rnd(), ov(0,1,0,0,0,0,0,0,0,2'b00,2'b10,2'b00), {tag, ".jump"});
      default: pend = 2'b10;
    endcase
  endtask

  function automatic bit is_legal(input logic [5:0] o);
`ifdef MIPS_CTRL_BNE_EN
    if (o == BNE) return 1'b1;
`endif
    return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == ADDI) || (o == J);
  endfunction

  function automatic int rand_wait();
    if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, P + 1));
    return 0;
  endfunction

  initial begin
    logic [5:0] o;
    logic [5:0] legal_ops [7];
    legal_ops = '{LW, SW, RT, BEQ, BNE, ADDI, J};

    // Reset held for three rising edges with mem_ready high: enables stay low.
    step(1'b1, 1'b1, ov(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00), "reset1");
    step(1'b1, 1'b1, ov(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00), "reset2");

    run_instr(RT, 1'b0, 0, 0, "rtype");
    run_instr(LW, 1'b0, 0, 2, "lw_wait2");
    run_instr(BEQ, 1'b1, 0, 0, "beq_taken");
    run_instr(BEQ, 1'b0, 0, 0, "beq_not");
    run_instr(BNE, 1'b0, 0, 0, "bne_z0");
    run_instr(BNE, 1'b1, 0, 0, "bne_z1");
    run_instr(6'b111111, 1'b0, 0, 0, "illegal");
    run_instr(J, 1'b0, 0, 0, "j_after_ill");
    run_instr(SW, 1'b0, 0, int'(P) + 1, "sw_timeout");
    run_instr(ADDI, 1'b0, int'(P), 0, "addi_fetch_edge");
    run_instr(LW, 1'b0, 0, int'(P), "lw_rd_edge");
    run_instr(SW, 1'b0, 2, 1, "sw_waits");
    run_instr(RT, 1'b0, int'(P) + 1, 0, "fetch_timeout");
    run_instr(J, 1'b0, 0, 0, "j_after_tmo");

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do o = 6'($urandom_range(0, 63)); while (is_legal(o));
      end else begin
        o = legal_ops[$urandom_range(0, 6)];
      end
      run_instr(o, rnd(), rand_wait(), rand_wait(), "rand");
    end

    // Reset arriving while MEMWR sees mem_ready must suppress the write.
    cur_op = SW;
    cur_z = 1'b0;
    first_flags = pend;
    pend = 2'b00;
    push(1'b1, ov(1,1,1,0,0,0,0,0,0,2'b01,2'b00,2'b00), "rst_sw.fetch");
    push(1'b0, ov(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00), "rst_sw.decode");
    push(1'b0, ov(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), "rst_sw.memadr");
    step(1'b1, 1'b1, ov(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00), "rst_in_memwr");
    push(1'b0, ov(1,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00), "post_rst.fetch");
    push(1'b1, ov(1,1,1,0,0,0,0,0,0,2'b01,2'b00,2'b00), "post_rst.fetch2");
    push(1'b0, ov(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00), "post_rst.decode");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
